// File: rtl/pipeline_id_stage.sv
// RV64I instruction decode stage with register-file bypass and load-use hazard detection.
// Latency: one cycle from IF inputs to the ID/EX register; rs addresses and load_use_stall are combinational.
// Backpressure: stall_in freezes the ID/EX register; load_use_stall inserts a bubble while IF holds.
module pipeline_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush,
    input  logic [63:0] pc_IF,
    input  logic [31:0] instruction_IF,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        load_use_stall,
    output logic [63:0] pc_ID,
    output logic [31:0] instruction_ID,
    output logic [63:0] rs1_val_ID,
    output logic [63:0] rs2_val_ID,
    output logic [63:0] imm_ID,
    output logic [4:0]  rs1_ID,
    output logic [4:0]  rs2_ID,
    output logic [4:0]  rd_ID,
    output logic [2:0]  funct3_ID,
    output logic [3:0]  alu_op_ID,
    output logic        alu_src_ID,
    output logic        word_op_ID,
    output logic        mem_read_ID,
    output logic        mem_write_ID,
    output logic        reg_write_ID,
    output logic        branch_ID,
    output logic        jump_ID,
    output logic        jalr_ID,
    output logic        illegal_ID,
    output logic        valid_ID
);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        word_op;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        illegal;
        logic        valid;
    } id_t;

    // Bubble: everything zero except the canonical NOP encoding.
    localparam id_t BUBBLE = id_t'({64'd0, NOP_INSTR, 224'd0});

    // Register-type ops use bit 30 for SUB/SRA; immediate forms only for SRAI.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt, input logic reg_form);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (reg_form && alt) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [4:0]  rd_f;
    logic [2:0]  f3;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        uses_rs1, uses_rs2, writes_rd, empty_slot;
    id_t         dec;
    id_t         id_q;

    assign opcode   = instruction_IF[6:0];
    assign rd_f     = instruction_IF[11:7];
    assign f3       = instruction_IF[14:12];
    assign rs1_addr = instruction_IF[19:15];
    assign rs2_addr = instruction_IF[24:20];

    assign imm_i = {{52{instruction_IF[31]}}, instruction_IF[31:20]};
    assign imm_s = {{52{instruction_IF[31]}}, instruction_IF[31:25], instruction_IF[11:7]};
    assign imm_b = {{51{instruction_IF[31]}}, instruction_IF[31], instruction_IF[7],
                    instruction_IF[30:25], instruction_IF[11:8], 1'b0};
    assign imm_u = {{32{instruction_IF[31]}}, instruction_IF[31:12], 12'b0};
    assign imm_j = {{43{instruction_IF[31]}}, instruction_IF[31], instruction_IF[19:12],
                    instruction_IF[20], instruction_IF[30:21], 1'b0};

    assign empty_slot = (instruction_IF == 32'h0) || (instruction_IF == NOP_INSTR);

    // Decode the IF instruction into ID/EX fields, operand values with bypass, and source usage.
    always_comb begin
        dec         = '0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        writes_rd   = 1'b0;
        dec.pc      = pc_IF;
        dec.instr   = instruction_IF;
        dec.rs1     = rs1_addr;
        dec.rs2     = rs2_addr;
        dec.rd      = rd_f;
        dec.funct3  = f3;
        dec.valid   = 1'b1;
        dec.rs1_val = (rs1_addr == 5'd0) ? 64'd0 :
                      (wb_reg_write && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
        dec.rs2_val = (rs2_addr == 5'd0) ? 64'd0 :
                      (wb_reg_write && (wb_rd == rs2_addr)) ? wb_data : rs2_data;
        case (opcode)
            OPC_LUI: begin
                dec.imm = imm_u; dec.alu_op = ALU_PASS_B; dec.alu_src = 1'b1; writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm = imm_u; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; writes_rd = 1'b1;
            end
            OPC_JAL: begin
                dec.imm = imm_j; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.jump = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.jump = 1'b1;
                dec.jalr = 1'b1; writes_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
                writes_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                dec.imm = imm_s; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                dec.imm     = imm_i;
                dec.alu_op  = arith_op(f3, instruction_IF[30], 1'b0);
                dec.alu_src = 1'b1;
                dec.word_op = (opcode == OPC_OPIMM32);
                writes_rd   = 1'b1;
                uses_rs1    = 1'b1;
            end
            OPC_OP, OPC_OP32: begin
                dec.alu_op  = arith_op(f3, instruction_IF[30], 1'b1);
                dec.word_op = (opcode == OPC_OP32);
                writes_rd   = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.reg_write = writes_rd && (rd_f != 5'd0);
    end

    // Hazard: a load in EX targets a source this instruction really reads.
    assign load_use_stall = !reset && !flush && ex_mem_read && (ex_rd != 5'd0) &&
                            ((uses_rs1 && (ex_rd == rs1_addr)) || (uses_rs2 && (ex_rd == rs2_addr)));

    // ID/EX register: reset > flush > stall_in > load-use bubble > normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q <= BUBBLE;
        end else if (flush) begin
            id_q <= BUBBLE;
        end else if (!stall_in) begin
            id_q <= (load_use_stall || empty_slot) ? BUBBLE : dec;
        end
    end

    assign pc_ID          = id_q.pc;
    assign instruction_ID = id_q.instr;
    assign rs1_val_ID     = id_q.rs1_val;
    assign rs2_val_ID     = id_q.rs2_val;
    assign imm_ID         = id_q.imm;
    assign rs1_ID         = id_q.rs1;
    assign rs2_ID         = id_q.rs2;
    assign rd_ID          = id_q.rd;
    assign funct3_ID      = id_q.funct3;
    assign alu_op_ID      = id_q.alu_op;
    assign alu_src_ID     = id_q.alu_src;
    assign word_op_ID     = id_q.word_op;
    assign mem_read_ID    = id_q.mem_read;
    assign mem_write_ID   = id_q.mem_write;
    assign reg_write_ID   = id_q.reg_write;
    assign branch_ID      = id_q.branch;
    assign jump_ID        = id_q.jump;
    assign jalr_ID        = id_q.jalr;
    assign illegal_ID     = id_q.illegal;
    assign valid_ID       = id_q.valid;

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Bench for pipeline_id_stage: directed scenarios plus randomized traffic against a reference model.
// The model tracks the expected ID register contents one cycle ahead of each rising edge.
// Inputs change 1ns after the rising edge; outputs are compared at the same point.
`timescale 1ns/1ps
module tb_pipeline_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [319:0] BUBBLE_V = {64'd0, NOP, 224'd0};

    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BRANCH = 4, K_LOAD = 5;
    localparam int K_STORE = 6, K_OPIMM = 7, K_OP = 8, K_OPIMM32 = 9, K_OP32 = 10, K_BAD = 11;
    localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    localparam logic [6:0] OPS [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h00};

    logic        clk = 1'b0;
    logic        reset, stall_in, flush;
    logic [63:0] pc_IF;
    logic [31:0] instruction_IF;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        load_use_stall;
    logic [63:0] pc_ID, rs1_val_ID, rs2_val_ID, imm_ID;
    logic [31:0] instruction_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic [2:0]  funct3_ID;
    logic [3:0]  alu_op_ID;
    logic        alu_src_ID, word_op_ID, mem_read_ID, mem_write_ID, reg_write_ID;
    logic        branch_ID, jump_ID, jalr_ID, illegal_ID, valid_ID;

    int total = 0;
    int passed = 0;
    logic [319:0] exp_vec;
    wire  [319:0] obs_vec = {pc_ID, instruction_ID, rs1_val_ID, rs2_val_ID, imm_ID, rs1_ID, rs2_ID,
                             rd_ID, funct3_ID, alu_op_ID, alu_src_ID, word_op_ID, mem_read_ID,
                             mem_write_ID, reg_write_ID, branch_ID, jump_ID, jalr_ID, illegal_ID,
                             valid_ID};

    always #5 clk = ~clk;

    pipeline_id_stage #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush),
        .pc_IF(pc_IF), .instruction_IF(instruction_IF),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .load_use_stall(load_use_stall),
        .pc_ID(pc_ID), .instruction_ID(instruction_ID), .rs1_val_ID(rs1_val_ID),
        .rs2_val_ID(rs2_val_ID), .imm_ID(imm_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rd_ID(rd_ID), .funct3_ID(funct3_ID), .alu_op_ID(alu_op_ID), .alu_src_ID(alu_src_ID),
        .word_op_ID(word_op_ID), .mem_read_ID(mem_read_ID), .mem_write_ID(mem_write_ID),
        .reg_write_ID(reg_write_ID), .branch_ID(branch_ID), .jump_ID(jump_ID),
        .jalr_ID(jalr_ID), .illegal_ID(illegal_ID), .valid_ID(valid_ID)
    );

    // ---------------- reference model ----------------
    function automatic int kind(input logic [6:0] op);
        for (int i = 0; i < 11; i++)
            if (OPS[i] == op) return i;
        return K_BAD;
    endfunction

    function automatic logic model_lus();
        int   k = kind(instruction_IF[6:0]);
        logic u1, u2;
        if (reset || flush || !ex_mem_read || ex_rd == 5'd0) return 1'b0;
        u1 = !(k == K_LUI || k == K_AUIPC || k == K_JAL || k == K_BAD);
        u2 = (k == K_OP || k == K_OP32 || k == K_BRANCH || k == K_STORE);
        return (u1 && ex_rd == instruction_IF[19:15]) || (u2 && ex_rd == instruction_IF[24:20]);
    endfunction

    function automatic logic [319:0] model_decode();
        logic [31:0] ins = instruction_IF;
        int k = kind(ins[6:0]);
        logic signed [63:0] t;
        logic [63:0] imm, v1, v2;
        logic [4:0]  r1, r2, rd;
        logic [3:0]  alu;
        logic src, word, mr, mw, rw, br, j, jr, ill;
        r1 = ins[19:15]; r2 = ins[24:20]; rd = ins[11:7];
        v1 = (r1 == 0) ? 64'd0 : (wb_reg_write && wb_rd == r1) ? wb_data : rs1_data;
        v2 = (r2 == 0) ? 64'd0 : (wb_reg_write && wb_rd == r2) ? wb_data : rs2_data;
        imm = 64'd0; alu = 4'd0;
        {src, word, mr, mw, rw, br, j, jr, ill} = 9'b0;
        // Immediates: place the field at the top of 64 bits, then arithmetic-shift down.
        case (k)
            K_LUI, K_AUIPC: begin t = {ins[31:12], 12'b0, 32'b0}; imm = t >>> 32; end
            K_JAL:    begin t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 43'b0}; imm = t >>> 43; end
            K_BRANCH: begin t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 51'b0}; imm = t >>> 51; end
            K_STORE:  begin t = {ins[31:25], ins[11:7], 52'b0}; imm = t >>> 52; end
            K_JALR, K_LOAD, K_OPIMM, K_OPIMM32: begin t = {ins, 32'b0}; imm = t >>> 52; end
            default:  imm = 64'd0;
        endcase
        src  = (k != K_BRANCH && k != K_OP && k != K_OP32 && k != K_BAD);
        rw   = !(k == K_BRANCH || k == K_STORE || k == K_BAD) && rd != 0;
        word = (k == K_OP32 || k == K_OPIMM32);
        mr   = (k == K_LOAD);
        mw   = (k == K_STORE);
        br   = (k == K_BRANCH);
        j    = (k == K_JAL || k == K_JALR);
        jr   = (k == K_JALR);
        ill  = (k == K_BAD);
        if (k == K_LUI) alu = 4'd10;
        else if (k == K_BRANCH) alu = 4'd1;
        else if (k >= K_OPIMM && k <= K_OP32) begin
            alu = ALU_TAB[ins[14:12]];
            if (ins[14:12] == 3'd5 && ins[30]) alu = 4'd7;
            if ((k == K_OP || k == K_OP32) && ins[14:12] == 3'd0 && ins[30]) alu = 4'd1;
        end
        return {pc_IF, ins, v1, v2, imm, r1, r2, rd, ins[14:12], alu,
                src, word, mr, mw, rw, br, j, jr, ill, 1'b1};
    endfunction

    function automatic logic [319:0] model_next();
        if (reset || flush) return BUBBLE_V;
        if (stall_in) return exp_vec;
        if (model_lus()) return BUBBLE_V;
        if (instruction_IF == 32'h0 || instruction_IF == NOP) return BUBBLE_V;
        return model_decode();
    endfunction

    // Advance one clock; the model's prediction becomes the expectation.
    task automatic cycle();
        logic [319:0] nxt;
        nxt = model_next();
        @(posedge clk);
        #1;
        exp_vec = nxt;
    endtask

    task automatic rand_inputs(input int p_flush, input int p_stall, input int p_reset);
        int sel;
        sel = int'($urandom_range(0, 11));
        instruction_IF = {$urandom} ;
        instruction_IF[6:0] = OPS[sel];
        if (sel == 11 && instruction_IF == 32'h0) instruction_IF = 32'h0000_1000;
        case ($urandom_range(0, 15))
            0: instruction_IF = 32'h0;
            1: instruction_IF = NOP;
            default: ;
        endcase
        pc_IF        = {$urandom, $urandom};
        rs1_data     = {$urandom, $urandom};
        rs2_data     = {$urandom, $urandom};
        wb_data      = {$urandom, $urandom};
        wb_reg_write = 1'($urandom_range(0, 1));
        ex_mem_read  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0, 1: ex_rd = instruction_IF[19:15];
            2:    ex_rd = instruction_IF[24:20];
            default: ex_rd = 5'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: wb_rd = instruction_IF[19:15];
            1: wb_rd = instruction_IF[24:20];
            default: wb_rd = 5'($urandom);
        endcase
        flush    = ($urandom_range(0, 99) < p_flush);
        stall_in = ($urandom_range(0, 99) < p_stall);
        reset    = ($urandom_range(0, 99) < p_reset);
    endtask

    task automatic quiet_inputs();
        reset = 1'b0; stall_in = 1'b0; flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        rs1_data = 64'd0; rs2_data = 64'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rand_inputs(0, 0, 0);
        reset = 1'b1; stall_in = 1'b1;
        instruction_IF = 32'h006281B3; ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        total++;
        if (load_use_stall !== 1'b0) $display("FAIL reset_lus: got %b want 0", load_use_stall);
        else passed++;
        cycle();
        cycle();
        total++;
        if (obs_vec !== exp_vec) $display("FAIL reset_state: got %h want %h", obs_vec, exp_vec);
        else passed++;
        total++;
        if (instruction_ID !== NOP || valid_ID !== 1'b0)
            $display("FAIL reset_nop: got instr %h valid %b want %h valid 0", instruction_ID, valid_ID, NOP);
        else passed++;
    endtask

    task automatic test_addi();
        quiet_inputs();
        instruction_IF = 32'hFFF00093; pc_IF = 64'h100;
        cycle();
        total++;
        if ({imm_ID, rd_ID, alu_op_ID, alu_src_ID, reg_write_ID, valid_ID, pc_ID} !==
            {64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 4'd0, 1'b1, 1'b1, 1'b1, 64'h100})
            $display("FAIL addi: got imm %h rd %0d alu %0d src %b rw %b vld %b pc %h", imm_ID, rd_ID,
                     alu_op_ID, alu_src_ID, reg_write_ID, valid_ID, pc_ID);
        else passed++;
        total++;
        if (obs_vec !== exp_vec) $display("FAIL addi_model: got %h want %h", obs_vec, exp_vec);
        else passed++;
    endtask

    task automatic test_load_use();
        quiet_inputs();
        instruction_IF = 32'h006281B3; pc_IF = 64'h200; ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        total++;
        if (load_use_stall !== 1'b1) $display("FAIL load_use_flag: got %b want 1", load_use_stall);
        else passed++;
        cycle();
        total++;
        if (valid_ID !== 1'b0 || obs_vec !== exp_vec)
            $display("FAIL load_use_bubble: got %h want %h", obs_vec, exp_vec);
        else passed++;
        ex_mem_read = 1'b0;
        cycle();
        total++;
        if (valid_ID !== 1'b1 || rs1_ID !== 5'd5 || rd_ID !== 5'd3)
            $display("FAIL load_use_retry: got valid %b rs1 %0d rd %0d want 1 5 3", valid_ID, rs1_ID, rd_ID);
        else passed++;
        // lui does not read rs1, so a matching load in EX is not a hazard
        instruction_IF = 32'h000282B7; ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        total++;
        if (load_use_stall !== 1'b0) $display("FAIL load_use_lui: got %b want 0", load_use_stall);
        else passed++;
        cycle();
    endtask

    task automatic test_bypass();
        quiet_inputs();
        instruction_IF = 32'h006281B3; wb_reg_write = 1'b1; wb_rd = 5'd6;
        wb_data = 64'h1234; rs2_data = 64'hDEAD; rs1_data = 64'h55;
        cycle();
        total++;
        if (rs2_val_ID !== 64'h1234 || rs1_val_ID !== 64'h55)
            $display("FAIL bypass_rs2: got rs2 %h rs1 %h want 1234 55", rs2_val_ID, rs1_val_ID);
        else passed++;
        // add x3,x0,x6 with a writeback aimed at x0: x0 still reads zero
        instruction_IF = 32'h006001B3; wb_rd = 5'd0; wb_data = 64'h77; rs1_data = 64'hBEEF;
        cycle();
        total++;
        if (rs1_val_ID !== 64'd0 || obs_vec !== exp_vec)
            $display("FAIL bypass_x0: got rs1 %h want 0", rs1_val_ID);
        else passed++;
    endtask

    task automatic test_flush_stall();
        quiet_inputs();
        instruction_IF = 32'h006281B3;
        cycle();
        flush = 1'b1; stall_in = 1'b1;
        cycle();
        total++;
        if (valid_ID !== 1'b0 || instruction_ID !== 32'h00000013)
            $display("FAIL flush_stall: got valid %b instr %h want 0 00000013", valid_ID, instruction_ID);
        else passed++;
        flush = 1'b0; stall_in = 1'b0;
    endtask

    task automatic test_hold();
        logic [319:0] held;
        quiet_inputs();
        instruction_IF = 32'h00A3_0663; pc_IF = 64'h300; rs1_data = 64'h11; rs2_data = 64'h22;
        cycle();
        held = exp_vec;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(0, 100, 0);
            cycle();
            total++;
            if (obs_vec !== held) $display("FAIL hold_%0d: got %h want %h", i, obs_vec, held);
            else passed++;
        end
        stall_in = 1'b0;
    endtask

    task automatic test_illegal();
        quiet_inputs();
        instruction_IF = 32'h00A0_0F80;
        cycle();
        total++;
        if ({illegal_ID, valid_ID, reg_write_ID, mem_read_ID, mem_write_ID, branch_ID, jump_ID, jalr_ID}
            !== 8'b1100_0000)
            $display("FAIL illegal: got ill %b vld %b rw %b mr %b mw %b br %b j %b jr %b", illegal_ID,
                     valid_ID, reg_write_ID, mem_read_ID, mem_write_ID, branch_ID, jump_ID, jalr_ID);
        else passed++;
    endtask

    task automatic test_reset_mid();
        quiet_inputs();
        instruction_IF = 32'h006281B3;
        cycle();
        reset = 1'b1; stall_in = 1'b1; flush = 1'b1;
        cycle();
        total++;
        if (obs_vec !== BUBBLE_V) $display("FAIL reset_mid: got %h want %h", obs_vec, BUBBLE_V);
        else passed++;
        reset = 1'b0; stall_in = 1'b0; flush = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(10, 15, 2);
            #1;
            total++;
            if (load_use_stall !== model_lus() || rs1_addr !== instruction_IF[19:15] ||
                rs2_addr !== instruction_IF[24:20])
                $display("FAIL rand_comb_%0d: got lus %b rs %0d/%0d want lus %b ins %h", i,
                         load_use_stall, rs1_addr, rs2_addr, model_lus(), instruction_IF);
            else passed++;
            cycle();
            total++;
            if (obs_vec !== exp_vec) $display("FAIL rand_%0d: got %h want %h", i, obs_vec, exp_vec);
            else passed++;
        end
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        pc_IF = 64'd0;
        instruction_IF = 32'd0;
        test_reset();
        test_addi();
        test_load_use();
        test_bypass();
        test_flush_stall();
        test_hold();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_id_stage.md
PIPELINE_ID_STAGE -- requirements
Module: pipeline_id_stage

Interface
REQ-001 Parameter: NOP_INSTR, default 32'h0000_0013, encoding treated as a bubble (valid_ID=0).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 stall_in  in  1  external hold (memory busy); freezes the ID/EX register.
REQ-005 flush  in  1  branch taken in EX; kills the instruction now in ID.
REQ-006 pc_IF  in  64  PC of the instruction presented by IF.
REQ-007 instruction_IF  in  32  instruction presented by IF; 32'h0 means empty slot.
REQ-008 rs1_addr, rs2_addr  out  5 each  combinational register-file read addresses, taken from instruction_IF[19:15] and instruction_IF[24:20].
REQ-009 rs1_data, rs2_data  in  64 each  combinational register-file read data.
REQ-010 wb_reg_write  in  1, wb_rd  in  5, wb_data  in  64  same-cycle writeback port used for the bypass.
REQ-011 ex_mem_read  in  1, ex_rd  in  5  load-in-EX information for hazard detection.
REQ-012 load_use_stall  out  1  combinational; drives the IF-stage stall together with stall_in.
REQ-013 Registered outputs: pc_ID 64, instruction_ID 32, rs1_val_ID 64, rs2_val_ID 64, imm_ID 64, rs1_ID 5, rs2_ID 5, rd_ID 5, funct3_ID 3, alu_op_ID 4, alu_src_ID 1, word_op_ID 1, mem_read_ID 1, mem_write_ID 1, reg_write_ID 1, branch_ID 1, jump_ID 1, jalr_ID 1, illegal_ID 1, valid_ID 1.

Function
REQ-014 Decode SHALL cover RV64I: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32.
REQ-015 imm_ID SHALL be the sign-extended 64-bit I, S, B, U, or J immediate for the opcode. It SHALL be 0 for OP.
REQ-016 alu_op codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - LUI uses PASS_B.
  - AUIPC, LOAD, STORE, JAL and JALR use ADD.
  - BRANCH uses SUB.
REQ-017 word_op_ID SHALL be 1 for OP-32 and OP-IMM-32 only.
REQ-018 alu_src_ID SHALL be 1 (immediate operand) for LUI, AUIPC, LOAD, STORE, OP-IMM, OP-IMM-32, JAL and JALR.
REQ-019 reg_write_ID SHALL be 0 when rd=0, and 0 for BRANCH and STORE.
REQ-020 Bypass: if wb_reg_write=1, wb_rd!=0 and wb_rd equals rs1_addr, rs1_val_ID SHALL capture wb_data instead of rs1_data. The same rule applies to rs2. Register x0 SHALL always read as 0.
REQ-021 load_use_stall SHALL be 1 when all of the following hold:
  - ex_mem_read=1 and ex_rd!=0;
  - ex_rd equals a source register the decoded instruction actually uses (rs1 unused by LUI, AUIPC, JAL; rs2 used only by OP, OP-32, BRANCH, STORE);
  - flush=0.
REQ-022 Unknown opcode SHALL produce illegal_ID=1, valid_ID=1, and all write/memory/branch controls 0.
REQ-023 Latency: one cycle from IF inputs to the ID registers.
REQ-024 Update priority each edge: reset > flush > stall_in > load_use_stall > normal load.
REQ-025 flush SHALL load a bubble:
  - valid_ID=0;
  - all control bits 0;
  - instruction_ID=NOP_INSTR;
  - other fields 0.
REQ-026 stall_in=1 (no flush) SHALL hold every ID register unchanged.
REQ-027 load_use_stall=1 (no stall_in) SHALL load a bubble. IF holds, so the same instruction re-decodes the next cycle.
REQ-028 instruction_IF equal to 0 or NOP_INSTR SHALL load a bubble with valid_ID=0.

Reset
REQ-029 On reset every registered output SHALL be 0, except instruction_ID=NOP_INSTR.
REQ-030 load_use_stall SHALL be 0 while reset is 1.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both within the same edge.

Verification
REQ-032 ADDI: instruction_IF=32'hFFF00093 (addi x1,x0,-1), pc_IF=0x100 -> next cycle:
  - imm_ID=64'hFFFF_FFFF_FFFF_FFFF, rd_ID=1, alu_op_ID=0, alu_src_ID=1, reg_write_ID=1, valid_ID=1, pc_ID=0x100.
REQ-033 Load-use: ex_mem_read=1, ex_rd=5, instruction add x3,x5,x6 -> load_use_stall=1 and a bubble is loaded. The next cycle with ex_mem_read=0 -> valid_ID=1, rs1_ID=5.
REQ-034 Bypass: wb_reg_write=1, wb_rd=6, wb_data=0x1234, rs2_data=0xDEAD, instruction uses rs2=x6 -> rs2_val_ID=0x1234.
REQ-035 Flush during stall: flush=1 and stall_in=1 together -> valid_ID=0 and instruction_ID=32'h00000013.
REQ-036 Hold and illegal opcode:
  - stall_in=1 for 3 cycles with changing inputs -> all outputs unchanged.
  - opcode 7'b0000000 with nonzero instruction -> illegal_ID=1.
